// File: rtl/register_file.sv
// register_file: 32 x N architectural register file (x0..x31).
//   One synchronous write port (writeback) and two combinational read ports
//   (operand fetch), each read port built from one mux32 instance.
//   x0 has no storage and always reads zero.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset, clears x1..x31
//   wr_ena    in   write enable, sampled on rising clk
//   wr_addr   in   [4:0] destination register; 0 is discarded
//   wr_data   in   [N-1:0] write data
//   rd_addr0  in   [4:0] read port 0 index
//   rd_addr1  in   [4:0] read port 1 index
//   rd_data0  out  [N-1:0] read port 0 data
//   rd_data1  out  [N-1:0] read port 1 data
//
// Parameters:
//   N       data width
//   BYPASS  1 = forward a same-cycle write to a matching read port

// mux32: 32-to-1 selector of N-bit words.
//   din  in   32 x [N-1:0] candidate words
//   sel  in   [4:0] select
//   dout out  [N-1:0] selected word
module mux32 #(
    parameter int N = 32
) (
    input  logic [N-1:0] din [32],
    input  logic [4:0]   sel,
    output logic [N-1:0] dout
);
    always_comb begin
        dout = din[sel];
    end
endmodule

module register_file #(
    parameter int N      = 32,
    parameter int BYPASS = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_ena,
    input  logic [4:0]   wr_addr,
    input  logic [N-1:0] wr_data,
    input  logic [4:0]   rd_addr0,
    input  logic [4:0]   rd_addr1,
    output logic [N-1:0] rd_data0,
    output logic [N-1:0] rd_data1
);

    logic [N-1:0] regs   [1:31];
    logic [N-1:0] mux_in [32];
    logic [31:1]  wr_sel;
    logic [N-1:0] mux_out0;
    logic [N-1:0] mux_out1;
    logic         bypass_ok;

    // One-hot write decode; address 0 has no bit, so x0 writes fall away.
    always_comb begin
        wr_sel = '0;
        for (int i = 1; i < 32; i++) begin
            wr_sel[i] = wr_ena && (wr_addr == 5'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (wr_sel[i]) begin
                    regs[i] <= wr_data;
                end
            end
        end
    end

    always_comb begin
        mux_in[0] = '0;
        for (int i = 1; i < 32; i++) begin
            mux_in[i] = regs[i];
        end
    end

    mux32 #(.N(N)) u_mux0 (
        .din  (mux_in),
        .sel  (rd_addr0),
        .dout (mux_out0)
    );

    mux32 #(.N(N)) u_mux1 (
        .din  (mux_in),
        .sel  (rd_addr1),
        .dout (mux_out1)
    );

    // Forwarding is suppressed in reset and for x0 so both always read zero.
    assign bypass_ok = (BYPASS != 0) && !rst && wr_ena && (wr_addr != 5'd0);

    always_comb begin
        rd_data0 = mux_out0;
        rd_data1 = mux_out1;
        if (bypass_ok && (rd_addr0 == wr_addr)) begin
            rd_data0 = wr_data;
        end
        if (bypass_ok && (rd_addr1 == wr_addr)) begin
            rd_data1 = wr_data;
        end
    end

endmodule

// File: tb/tb_register_file.sv
module tb_register_file;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         wr_ena;
    logic [4:0]   wr_addr;
    logic [N-1:0] wr_data;
    logic [4:0]   rd_addr0;
    logic [4:0]   rd_addr1;
    logic [N-1:0] q0_b0, q1_b0, q0_b1, q1_b1;

    int checks = 0;
    int errors = 0;
    logic [N-1:0] model [32];

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e0_b0;
        logic [31:0] e1_b0;
        logic [31:0] e0_b1;
        logic [31:0] e1_b1;
    } vec_t;

    vec_t vecs [13];

    always #5 clk = ~clk;

    register_file #(.N(N), .BYPASS(0)) u_dut0 (
        .clk(clk), .rst(rst), .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .rd_data0(q0_b0), .rd_data1(q1_b0)
    );

    register_file #(.N(N), .BYPASS(1)) u_dut1 (
        .clk(clk), .rst(rst), .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .rd_data0(q0_b1), .rd_data1(q1_b1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input logic [31:0] e0_b0, input logic [31:0] e1_b0,
                             input logic [31:0] e0_b1, input logic [31:0] e1_b1);
        check({name, " b0 p0"}, q0_b0, e0_b0);
        check({name, " b0 p1"}, q1_b0, e1_b0);
        check({name, " b1 p0"}, q0_b1, e0_b1);
        check({name, " b1 p1"}, q1_b1, e1_b1);
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        wr_ena  = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(posedge clk);
        #1;
        wr_ena  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        wr_ena   = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        rd_addr0 = 5'd3;
        rd_addr1 = 5'd31;

        // Hand-computed directed table, starting from an all-zero file.
        // Expected values are sampled before the clock edge of each row.
        vecs[0]  = '{1'b1, 5'd5,  32'h0000_0011, 5'd5,  5'd0,  32'h0,         32'h0,         32'h0000_0011, 32'h0};
        vecs[1]  = '{1'b1, 5'd5,  32'h0000_0022, 5'd5,  5'd5,  32'h0000_0011, 32'h0000_0011, 32'h0000_0022, 32'h0000_0022};
        vecs[2]  = '{1'b0, 5'd5,  32'h0000_0033, 5'd5,  5'd6,  32'h0000_0022, 32'h0,         32'h0000_0022, 32'h0};
        vecs[3]  = '{1'b1, 5'd0,  32'hDEAD_BEEF, 5'd0,  5'd5,  32'h0,         32'h0000_0022, 32'h0,         32'h0000_0022};
        vecs[4]  = '{1'b0, 5'd0,  32'h0,         5'd0,  5'd5,  32'h0,         32'h0000_0022, 32'h0,         32'h0000_0022};
        vecs[5]  = '{1'b1, 5'd31, 32'hA5A5_A5A5, 5'd31, 5'd30, 32'h0,         32'h0,         32'hA5A5_A5A5, 32'h0};
        vecs[6]  = '{1'b1, 5'd1,  32'h0123_4567, 5'd31, 5'd1,  32'hA5A5_A5A5, 32'h0,         32'hA5A5_A5A5, 32'h0123_4567};
        vecs[7]  = '{1'b1, 5'd30, 32'hFFFF_FFFF, 5'd1,  5'd30, 32'h0123_4567, 32'h0,         32'h0123_4567, 32'hFFFF_FFFF};
        vecs[8]  = '{1'b0, 5'd30, 32'h0,         5'd30, 5'd31, 32'hFFFF_FFFF, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 32'hA5A5_A5A5};
        vecs[9]  = '{1'b1, 5'd7,  32'h0000_00AA, 5'd6,  5'd7,  32'h0,         32'h0,         32'h0,         32'h0000_00AA};
        vecs[10] = '{1'b0, 5'd0,  32'h0,         5'd7,  5'd5,  32'h0000_00AA, 32'h0000_0022, 32'h0000_00AA, 32'h0000_0022};
        vecs[11] = '{1'b1, 5'd5,  32'h0000_0055, 5'd1,  5'd1,  32'h0123_4567, 32'h0123_4567, 32'h0123_4567, 32'h0123_4567};
        vecs[12] = '{1'b0, 5'd0,  32'h0,         5'd5,  5'd0,  32'h0000_0055, 32'h0,         32'h0000_0055, 32'h0};

        // Reset state
        #1;
        check_all("reset", 32'h0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Async reset with no clock edge needed
        for (int k = 1; k < 32; k++) write_reg(5'(k), 32'hFFFF_FFFF);
        @(negedge clk);
        rd_addr0 = 5'd9;
        rd_addr1 = 5'd31;
        #1;
        check_all("preload", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        #1;
        rst = 1'b1;
        for (int a = 0; a < 32; a++) begin
            rd_addr0 = 5'(a);
            rd_addr1 = 5'(31 - a);
            #1;
            check_all("async reset", 32'h0, 32'h0, 32'h0, 32'h0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Write/readback sweep
        for (int k = 1; k < 32; k++) write_reg(5'(k), 32'h1000_0000 + k);
        for (int a = 0; a < 32; a++) begin
            logic [31:0] e0, e1;
            rd_addr0 = 5'(a);
            rd_addr1 = 5'(31 - a);
            e0 = (a == 0) ? 32'h0 : 32'h1000_0000 + a;
            e1 = (a == 31) ? 32'h0 : 32'h1000_0000 + (31 - a);
            #1;
            check_all("readback", e0, e1, e0, e1);
        end

        // x0 protect
        write_reg(5'd0, 32'hDEAD_BEEF);
        rd_addr0 = 5'd0;
        rd_addr1 = 5'd1;
        #1;
        check_all("x0 protect", 32'h0, 32'h1000_0001, 32'h0, 32'h1000_0001);
        for (int a = 1; a < 32; a++) begin
            rd_addr0 = 5'(a);
            #1;
            check("x0 others b0", q0_b0, 32'h1000_0000 + a);
            check("x0 others b1", q0_b1, 32'h1000_0000 + a);
        end

        // Directed table
        do_reset();
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            wr_ena   = vecs[i].we;
            wr_addr  = vecs[i].wa;
            wr_data  = vecs[i].wd;
            rd_addr0 = vecs[i].ra0;
            rd_addr1 = vecs[i].ra1;
            #2;
            check_all($sformatf("vec%0d", i), vecs[i].e0_b0, vecs[i].e1_b0, vecs[i].e0_b1, vecs[i].e1_b1);
        end
        @(negedge clk);
        wr_ena = 1'b0;

        // Reset coincident with a write edge
        write_reg(5'd7, 32'h0000_0013);
        @(negedge clk);
        wr_ena   = 1'b1;
        wr_addr  = 5'd7;
        wr_data  = 32'h0000_00AA;
        rd_addr0 = 5'd7;
        rd_addr1 = 5'd7;
        @(posedge clk);
        rst = 1'b1;
        #2;
        check_all("rst bypass off", 32'h0, 32'h0, 32'h0, 32'h0);
        @(posedge clk);
        #2;
        check_all("rst hold write", 32'h0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        wr_ena = 1'b0;
        rst    = 1'b0;
        #1;
        check_all("rst mid write", 32'h0, 32'h0, 32'h0, 32'h0);

        // First edge after reset release performs a write
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        wr_ena   = 1'b1;
        wr_addr  = 5'd9;
        wr_data  = 32'h0000_0099;
        rd_addr0 = 5'd9;
        rd_addr1 = 5'd9;
        @(posedge clk);
        #1;
        wr_ena = 1'b0;
        #1;
        check_all("release write", 32'h99, 32'h99, 32'h99, 32'h99);

        // Random against a reference array
        do_reset();
        for (int k = 0; k < 32; k++) model[k] = '0;
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] e0, e1, f0, f1;
            @(negedge clk);
            wr_ena   = 1'($urandom_range(0, 1));
            wr_addr  = 5'($urandom_range(0, 31));
            wr_data  = $urandom;
            rd_addr0 = 5'($urandom_range(0, 31));
            rd_addr1 = 5'($urandom_range(0, 31));
            #2;
            e0 = model[rd_addr0];
            e1 = model[rd_addr1];
            f0 = (wr_ena && wr_addr != 0 && wr_addr == rd_addr0) ? wr_data : e0;
            f1 = (wr_ena && wr_addr != 0 && wr_addr == rd_addr1) ? wr_data : e1;
            check_all("random", e0, e1, f0, f1);
            @(posedge clk);
            if (wr_ena && wr_addr != 0) model[wr_addr] = wr_data;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
